// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Configuration macro: INST_FETCH_BYPASS_EN (see inst_fetch_buf.sv).
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {inst, pc} entries with a single-cycle flush.
// DEPTH must be a power of two (pointers wrap naturally).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output fetch_entry_t             head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    fetch_entry_t     mem_q [DEPTH];

    // Storage, pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{inst: 32'h0, pc: 32'h0};
            end
        end else if (flush_i) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            // When full, push and pop together overwrite the slot being popped,
            // which is safe because the head is read combinationally this cycle.
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch front-end: issues one outstanding req/ack fetch at a time,
// buffers {inst, pc} in a FIFO and presents them on a valid/ready interface.
// A redirect flushes the buffer and restarts fetch at the new target.
// Optional macro INST_FETCH_BYPASS_EN: zero-latency ack-to-inst path when the
// buffer is empty.
module inst_fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        pcrst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             imem_req_q, imem_req_d;
    logic [31:0]      imem_addr_q, imem_addr_d;

    logic [CNT_W-1:0] fifo_count_s;
    logic [CNT_W-1:0] next_count_s;
    fetch_entry_t     fifo_head_s;
    fetch_entry_t     push_entry_s;
    logic             fifo_valid_s;
    logic             ack_take_s;
    logic             push_s;
    logic             pop_s;
`ifdef INST_FETCH_BYPASS_EN
    logic             bypass_s;
`endif
    logic             unused_rpc_s;

    // The low redirect target bits are forced to word alignment and never read.
    assign unused_rpc_s = ^redirect_pc[1:0];

    // Push/pop qualification, output selection and next FIFO occupancy.
    always_comb begin
        fifo_valid_s = (fifo_count_s != {CNT_W{1'b0}});
        pop_s        = fifo_valid_s && inst_ready;
        // Ack data is only kept for a live request that is not being redirected.
        ack_take_s   = (state_q == REQ) && imem_ack && !redirect;
        push_entry_s.inst = imem_rdata;
        push_entry_s.pc   = fetch_pc_q;
`ifdef INST_FETCH_BYPASS_EN
        bypass_s   = !fifo_valid_s && ack_take_s;
        push_s     = ack_take_s && !(bypass_s && inst_ready);
        inst_valid = fifo_valid_s || bypass_s;
`else
        push_s     = ack_take_s;
        inst_valid = fifo_valid_s;
`endif
        if (fifo_valid_s) begin
            inst    = fifo_head_s.inst;
            inst_pc = fifo_head_s.pc;
`ifdef INST_FETCH_BYPASS_EN
        end else if (bypass_s) begin
            inst    = imem_rdata;
            inst_pc = fetch_pc_q;
`endif
        end else begin
            inst    = 32'h0;
            inst_pc = 32'h0;
        end
        if (redirect) begin
            next_count_s = {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            next_count_s = fifo_count_s + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            next_count_s = fifo_count_s - CNT_W'(1);
        end else begin
            next_count_s = fifo_count_s;
        end
    end

    // Fetch FSM next state, fetch PC update and next request outputs.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // A request still in flight must be allowed to complete before the
            // new target can be requested.
            if (((state_q == REQ) || (state_q == DISCARD)) && !imem_ack) begin
                state_d = DISCARD;
            end else begin
                state_d = REQ;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (next_count_s < DEPTH_C) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        fetch_pc_d = fetch_pc_q + PC_INC;
                        state_d    = (next_count_s < DEPTH_C) ? REQ : IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_d = REQ;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        imem_req_d  = (state_d != IDLE);
        // While discarding, the stale address is held until its ack arrives.
        imem_addr_d = (state_d == DISCARD) ? imem_addr_q : fetch_pc_d;
    end

    // FSM state, fetch PC and registered memory request outputs.
    always_ff @(posedge clk or negedge pcrst) begin
        if (!pcrst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (pcrst),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .flush_i     (redirect),
        .count_o     (fifo_count_s),
        .head_o      (fifo_head_s)
    );

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: behavioural req/ack memory,
// scoreboard of expected {pc, inst} entries, directed redirect/reset scenarios.
module tb_inst_fetch_buf;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk         = 1'b0;
    logic        pcrst       = 1'b0;
    logic        imem_ack    = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready  = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          lat          = 1;
    int          ack_count    = 0;
    bit          ready_ctl    = 1'b0;
    bit          rst_req      = 1'b0;
    bit          redir_pend   = 1'b0;
    int          redir_mode   = 0;
    logic [31:0] redir_at     = 32'h0;
    logic [31:0] redir_target = 32'h0;
    logic [31:0] exp_pc       = RESET_PC;
    logic [63:0] exp_q [$];
    logic [31:0] post_q [$];

    inst_fetch_buf dut (
        .clk         (clk),
        .pcrst       (pcrst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] post_at(input int i);
        if (post_q.size() > i) return post_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_redir();
        for (int i = 0; i < 60; i++) begin
            if (!redir_pend) break;
            step(1);
        end
        check_eq("redir_fired", 32'(redir_pend), 32'h0);
    endtask

    // Memory model, redirect injection and scoreboard; owns every DUT input.
    initial begin : central
        int          cnt;
        bit          stale;
        bit          ack_now;
        bit          accept;
        bit          first_chk;
        logic [31:0] stale_addr;
        logic [63:0] e;
        cnt = 0; stale = 1'b0; first_chk = 1'b0; stale_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_req) begin
                rst_req = 1'b0; pcrst = 1'b0; imem_ack = 1'b0; redirect = 1'b0;
                cnt = 0; stale = 1'b0; exp_pc = RESET_PC;
                exp_q.delete(); post_q.delete();
                #1;
                check_eq("rst_req",   32'(imem_req),   32'h0);
                check_eq("rst_addr",  imem_addr,       RESET_PC);
                check_eq("rst_valid", 32'(inst_valid), 32'h0);
                check_eq("rst_inst",  inst,            32'h0);
                check_eq("rst_pc",    inst_pc,         32'h0);
                continue;
            end
            if (!pcrst) begin
                pcrst = 1'b1; first_chk = 1'b1;
            end else if (first_chk) begin
                first_chk = 1'b0;
                check_eq("first_req",  32'(imem_req), 32'h1);
                check_eq("first_addr", imem_addr,     RESET_PC);
            end
            ack_now = 1'b0;
            if (imem_ack) begin
                imem_ack = 1'b0;
                cnt = imem_req ? 1 : 0;
            end else if (imem_req) begin
                if (cnt >= lat) ack_now = 1'b1;
                else cnt++;
            end else begin
                cnt = 0;
            end
            if (ack_now) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end
            redirect = 1'b0;
            if (redir_pend) begin
                if ((redir_mode == 0) ||
                    (redir_mode == 1 && ack_now && imem_addr == redir_at) ||
                    (redir_mode == 2 && imem_req && !ack_now)) begin
                    redirect = 1'b1; redirect_pc = redir_target; redir_pend = 1'b0;
                end
            end
            inst_ready = ready_ctl;
            accept = ack_now && !redirect && !stale;
            if (ack_now) begin
                check_eq("ack_addr", imem_addr, stale ? stale_addr : exp_pc);
                ack_count++;
            end
`ifdef INST_FETCH_BYPASS_EN
            if (accept) exp_q.push_back({exp_pc, mem_word(exp_pc)});
`endif
            #1;
            check_eq("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
            if (inst_valid && inst_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("inst_pc", inst_pc, e[63:32]);
                check_eq("inst",    inst,    e[31:0]);
            end
`ifndef INST_FETCH_BYPASS_EN
            if (accept) exp_q.push_back({exp_pc, mem_word(exp_pc)});
`endif
            if (accept) begin
                post_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect) begin
                exp_q.delete(); post_q.delete();
                if (imem_req && !ack_now) begin
                    if (!stale) stale_addr = imem_addr;
                    stale = 1'b1;
                end else begin
                    stale = 1'b0;
                end
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (ack_now) begin
                stale = 1'b0;
            end
        end
    end

    // Directed scenario sequence.
    initial begin : main
        int a0;
        // Streaming from reset with a 1-cycle memory and the core always ready.
        lat = 1; ready_ctl = 1'b1; rst_req = 1'b1;
        step(30);

        // Reset pulse while a slow request is outstanding; fetch restarts at RESET_PC.
        lat = 3;
        for (int i = 0; i < 50; i++) begin
            if (imem_req) break;
            step(1);
        end
        check_eq("mid_req", 32'(imem_req), 32'h1);
        rst_req = 1'b1;
        step(25);

        // Back-pressure: exactly DEPTH acks, then no request until the core drains.
        lat = 1; ready_ctl = 1'b0; rst_req = 1'b1; a0 = ack_count;
        step(22);
        check_eq("bp_acks", 32'(ack_count - a0), 32'd4);
        check_eq("bp_req",  32'(imem_req),       32'h0);
        ready_ctl = 1'b1;
        step(15);

        // Redirect to 0x103 in the same cycle as the ack of 0x8.
        rst_req = 1'b1;
        step(2);
        redir_mode = 1; redir_at = 32'h8; redir_target = 32'h0000_0103; redir_pend = 1'b1;
        wait_redir();
        step(12);
        check_eq("rd_ack_addr", post_at(0), 32'h0000_0100);

        // Redirect to 0x40 while a 3-cycle request is waiting; stale word dropped.
        lat = 3;
        redir_mode = 2; redir_target = 32'h0000_0040; redir_pend = 1'b1;
        wait_redir();
        step(20);
        check_eq("rd_req_addr0", post_at(0), 32'h0000_0040);
        check_eq("rd_req_addr1", post_at(1), 32'h0000_0044);

        // Fetch PC wraps from 0xFFFF_FFFC to 0.
        lat = 1;
        redir_mode = 0; redir_target = 32'hFFFF_FFFE; redir_pend = 1'b1;
        wait_redir();
        step(12);
        check_eq("wrap_top",  post_at(0), 32'hFFFF_FFFC);
        check_eq("wrap_zero", post_at(1), 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit in case the sequence ever stalls.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch_buf.md
# inst_fetch_buf

Instruction fetch front-end for the single-cycle core. It sits directly upstream of the core's PC/instruction-memory path and drives a multi-cycle instruction memory through a req/ack handshake. Fetched words are buffered with their PCs in a small FIFO and presented to the core on a valid/ready interface. A redirect from the core's next-PC select (taken branch, `jr`, `j`) flushes the buffer and restarts fetch at the new address.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk` in 1: single clock; all state updates on the rising edge.
- `pcrst` in 1: asynchronous, active-low reset (0 = reset). Shares its name with the core's PC reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; word-aligned, bits [1:0] always 0.
- `imem_ack` in 1: memory accepted and completed the request; qualifies `imem_rdata`.
- `imem_rdata` in 32: fetched instruction word.
- `redirect` in 1: the core requests a non-sequential PC.
- `redirect_pc` in 32: the new fetch target; bits [1:0] are ignored.
- `inst_valid` out 1: `inst` and `inst_pc` are valid.
- `inst` out 32: instruction word for the core decoder.
- `inst_pc` out 32: address of `inst`. The core uses `inst_pc`+4 as npc0.
- `inst_ready` in 1: the core consumes the head entry this cycle.

## Operation
- `fetch_pc` register: holds the next address to request. It advances by 4 on each accepted ack and wraps modulo 2^32.
- At most one request is outstanding. A new request issues only when `count + outstanding < DEPTH`, so the FIFO never overflows.
- FSM states:
  - IDLE: request conditions not met.
  - REQ: `imem_req`=1 with `imem_addr`=`fetch_pc`. On `imem_ack`, push {`imem_rdata`, `fetch_pc`}, add 4 to `fetch_pc`, then go to REQ if space remains, else IDLE.
  - DISCARD: a redirect arrived while a request was outstanding. Hold `imem_req`/`imem_addr` at the stale address until ack. Drop the returned data, then go to REQ at the new `fetch_pc`.
- Redirect (highest priority):
  - Clear the FIFO.
  - Set `fetch_pc` to {`redirect_pc`[31:2], 2'b00}.
  - From REQ with no ack that cycle, go to DISCARD. Otherwise go to REQ.
- Pop: `inst_valid && inst_ready` removes the head entry.
- Simultaneous push and pop with the FIFO full: allowed, and `count` is unchanged.
- Redirect together with ack in the same cycle: the ack data is dropped and the next request goes to the redirect target.
- Redirect together with a pop: the pop completes, because the core has consumed that word, and the flush then applies.
- Redirect while in DISCARD: update `fetch_pc` again and stay in DISCARD.
- Reset mid-operation: all state is cleared immediately. Any in-flight memory response is ignored after `pcrst` rises; memory must also be reset by the same `pcrst`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0, state IDLE, `count`=0.
- First `imem_req` is asserted in the first cycle after `pcrst` deasserts.
- `imem_req` and `imem_addr` are registered and remain stable until the cycle `imem_ack` is sampled high.
- Ack-to-`inst_valid` latency is 1 cycle; the entry is visible the cycle after the ack.
- Back-to-back fetch: with a 1-cycle ack memory, throughput is one instruction every 2 cycles. The request re-asserts the cycle after the ack.
- Redirect-to-request latency: 1 cycle from IDLE/REQ. From DISCARD it is 1 cycle after the stale ack.
- `inst_valid` drops in the cycle after a redirect.

## Configuration
- `INST_FETCH_BYPASS_EN` defined:
  - When the FIFO is empty, `imem_ack` is high and `redirect` is low, `imem_rdata`/`fetch_pc` drive `inst`/`inst_pc` combinationally with `inst_valid`=1 in the ack cycle.
  - If `inst_ready` is also high, nothing is pushed.
  - Ack-to-valid latency is 0.
- Undefined: the 1-cycle registered path only. No combinational path from `imem_*` to `inst_*`.

## Structure
- Package `fetch_pkg`: `INST_W`=32, `PC_INC`=32'd4, the FSM state enum {IDLE, REQ, DISCARD}, and a packed struct {inst, pc} used for FIFO entries.
- One sub-module `fetch_fifo`: synchronous FIFO of `fetch_pkg` entries. Parameter `DEPTH`; inputs push, pop, flush; outputs count, head.
- The FSM and `fetch_pc` stay in `inst_fetch_buf`.

## Test plan
- Reset release, 1-cycle ack memory, `inst_ready`=1:
  - First request is at 0x0.
  - `inst_pc` sequence is 0x0, 0x4, 0x8, with `inst` matching memory.
- `inst_ready`=0 for 20 cycles:
  - Exactly `DEPTH`=4 acks occur, then `imem_req` stays 0.
  - Releasing ready drains 0x0–0xC in order.
- Redirect to 0x40 while in REQ, with ack delayed 3 cycles:
  - Stale word is dropped.
  - Next request is at 0x40; first `inst_pc`=0x40.
- Redirect to 0x103 in the same cycle as an ack at 0x8:
  - 0x8 is never presented.
  - Next `imem_addr`=0x100.
- `pcrst` low for one cycle mid-REQ:
  - All outputs return to reset values.
  - Fetch restarts at `RESET_PC`.
- `fetch_pc`=0xFFFF_FFFC is acked:
  - Next request is at 0x0000_0000.
- With `INST_FETCH_BYPASS_EN`: empty FIFO plus ack gives `inst_valid`=1 in the ack cycle.
